// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the sram-like bus arbiter.
package sram_arb_pkg;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_LOCK = 1'b1;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_fields_t;

  function automatic req_fields_t pick_fields(input logic sel,
                                              input req_fields_t inst_f,
                                              input req_fields_t data_f);
    if (sel == REQ_DATA) begin
      return data_f;
    end else begin
      return inst_f;
    end
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of 1-bit requester ids, one entry per accepted transaction.
module arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_push,
  input  logic i_push_id,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_id;
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the inst and data sram-like ports onto one master port and routes responses in order.
// Define ARB_RR_EN for round-robin arbitration; default is fixed data-over-inst priority.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  logic [0:0]  r_state;
  logic        r_owner;
  req_fields_t w_inst_f;
  req_fields_t w_data_f;
  req_fields_t w_sel_f;
  logic        w_winner;
  logic        w_grant_valid;
  logic        w_grant_id;
  logic        w_sel_req;
  logic        w_sram_req;
  logic        w_push;
  logic        w_pop;
  logic        w_resp_ok;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_fifo_head;

  assign w_inst_f = '{wr: inst_sram_wr, size: inst_sram_size, wstrb: inst_sram_wstrb,
                      addr: inst_sram_addr, wdata: inst_sram_wdata};
  assign w_data_f = '{wr: data_sram_wr, size: data_sram_size, wstrb: data_sram_wstrb,
                      addr: data_sram_addr, wdata: data_sram_wdata};

`ifdef ARB_RR_EN
  logic r_rr_ptr;

  // Preferred requester when both ask; only consulted on a tie.
  always_comb begin
    w_winner = REQ_INST;
    if (inst_sram_req & data_sram_req) begin
      w_winner = r_rr_ptr;
    end else if (data_sram_req) begin
      w_winner = REQ_DATA;
    end else begin
      w_winner = REQ_INST;
    end
  end

  // Pointer flips away from whoever was just accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr <= REQ_INST;
    end else if (w_push) begin
      r_rr_ptr <= ~w_grant_id;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`else
  // Fixed priority: data beats inst.
  always_comb begin
    w_winner = REQ_INST;
    if (data_sram_req) begin
      w_winner = REQ_DATA;
    end else begin
      w_winner = REQ_INST;
    end
  end
`endif

  // Grant selection; a full FIFO blocks new grants even if a pop is happening now.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = REQ_INST;
    if (!resetn) begin
      w_grant_valid = 1'b0;
    end else begin
      case (r_state)
        ARB_LOCK: begin
          w_grant_valid = 1'b1;
          w_grant_id    = r_owner;
        end
        ARB_IDLE: begin
          if (!w_fifo_full && (inst_sram_req || data_sram_req)) begin
            w_grant_valid = 1'b1;
            w_grant_id    = w_winner;
          end else begin
            w_grant_valid = 1'b0;
          end
        end
        default: w_grant_valid = 1'b0;
      endcase
    end
  end

  assign w_sel_req  = (w_grant_id == REQ_DATA) ? data_sram_req : inst_sram_req;
  assign w_sram_req = w_grant_valid & w_sel_req;
  assign w_sel_f    = pick_fields(w_grant_id, w_inst_f, w_data_f);
  assign w_push     = w_sram_req & sram_addr_ok;
  assign w_pop      = resetn & sram_data_ok;
  assign w_resp_ok  = w_pop & ~w_fifo_empty;

  // Master port fields are zeroed whenever nobody holds the grant.
  always_comb begin
    sram_req   = w_sram_req;
    sram_wr    = 1'b0;
    sram_size  = 2'b00;
    sram_wstrb = 4'b0000;
    sram_addr  = 32'h0000_0000;
    sram_wdata = 32'h0000_0000;
    if (w_grant_valid) begin
      sram_wr    = w_sram_req & w_sel_f.wr;
      sram_size  = w_sel_f.size;
      sram_wstrb = w_sel_f.wstrb;
      sram_addr  = w_sel_f.addr;
      sram_wdata = w_sel_f.wdata;
    end else begin
      sram_wr    = 1'b0;
    end
  end

  assign inst_sram_addr_ok = w_push & (w_grant_id == REQ_INST);
  assign data_sram_addr_ok = w_push & (w_grant_id == REQ_DATA);
  assign inst_sram_data_ok = w_resp_ok & (w_fifo_head == REQ_INST);
  assign data_sram_data_ok = w_resp_ok & (w_fifo_head == REQ_DATA);
  assign inst_sram_rdata   = inst_sram_data_ok ? sram_rdata : 32'h0000_0000;
  assign data_sram_rdata   = data_sram_data_ok ? sram_rdata : 32'h0000_0000;

  // Lock the winner until its address phase completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ARB_IDLE;
      r_owner <= REQ_INST;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_sram_req && !sram_addr_ok) begin
            r_state <= ARB_LOCK;
            r_owner <= w_grant_id;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_LOCK: begin
          if (sram_addr_ok) begin
            r_state <= ARB_IDLE;
          end else begin
            r_state <= ARB_LOCK;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  arb_tag_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_push    (w_push),
    .i_push_id (w_grant_id),
    .i_pop     (w_pop),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_head    (w_fifo_head)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter; round-robin expectations apply when ARB_RR_EN is defined.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, sram_size;
  logic [3:0]  inst_wstrb, data_wstrb, sram_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_aok, inst_dok, data_aok, data_dok;
  logic [31:0] inst_rdata, data_rdata;
  logic        sram_req, sram_wr, sram_addr_ok, sram_data_ok;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.OUTSTANDING(4)) dut (
    .clk (clk), .resetn (resetn),
    .inst_sram_req (inst_req), .inst_sram_wr (inst_wr), .inst_sram_size (inst_size),
    .inst_sram_wstrb (inst_wstrb), .inst_sram_addr (inst_addr), .inst_sram_wdata (inst_wdata),
    .inst_sram_addr_ok (inst_aok), .inst_sram_data_ok (inst_dok), .inst_sram_rdata (inst_rdata),
    .data_sram_req (data_req), .data_sram_wr (data_wr), .data_sram_size (data_size),
    .data_sram_wstrb (data_wstrb), .data_sram_addr (data_addr), .data_sram_wdata (data_wdata),
    .data_sram_addr_ok (data_aok), .data_sram_data_ok (data_dok), .data_sram_rdata (data_rdata),
    .sram_req (sram_req), .sram_wr (sram_wr), .sram_size (sram_size), .sram_wstrb (sram_wstrb),
    .sram_addr (sram_addr), .sram_wdata (sram_wdata), .sram_addr_ok (sram_addr_ok),
    .sram_data_ok (sram_data_ok), .sram_rdata (sram_rdata)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0;
    inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = 32'h0;
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    // reset: everything quiet despite active inputs
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1;
    sram_addr_ok = 1'b1; sram_data_ok = 1'b1; sram_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_val("rst_sram_req", {31'h0, sram_req}, 32'h0);
    check_val("rst_sram_wr", {31'h0, sram_wr}, 32'h0);
    check_val("rst_aok", {30'h0, inst_aok, data_aok}, 32'h0);
    check_val("rst_dok", {30'h0, inst_dok, data_dok}, 32'h0);
    check_val("rst_inst_rdata", inst_rdata, 32'h0);
    check_val("rst_data_rdata", data_rdata, 32'h0);
    next_cyc();
    clear_inputs();
    resetn = 1'b1;
    next_cyc();

`ifdef ARB_RR_EN
    // round-robin alternation starting with inst
    inst_req = 1'b1; data_req = 1'b1; sram_addr_ok = 1'b1;
    inst_addr = 32'h1C00_0000; data_addr = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("rr_inst_aok%0d", i), {31'h0, inst_aok}, (i % 2 == 0) ? 32'h1 : 32'h0);
      check_val($sformatf("rr_data_aok%0d", i), {31'h0, data_aok}, (i % 2 == 0) ? 32'h0 : 32'h1);
      next_cyc();
    end
    inst_req = 1'b0; data_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sram_rdata = 32'h100 + i;
      @(negedge clk);
      check_val($sformatf("rr_inst_dok%0d", i), {31'h0, inst_dok}, (i % 2 == 0) ? 32'h1 : 32'h0);
      next_cyc();
    end
    sram_data_ok = 1'b0;
`else
    // simultaneous requests: data first, inst next
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    data_req = 1'b1; data_addr = 32'h0000_1000; sram_addr_ok = 1'b1;
    @(negedge clk);
    check_val("t1_addr_data", sram_addr, 32'h0000_1000);
    check_val("t1_aok_data", {30'h0, inst_aok, data_aok}, 32'h1);
    next_cyc();
    data_req = 1'b0;
    @(negedge clk);
    check_val("t1_addr_inst", sram_addr, 32'h1C00_0000);
    check_val("t1_aok_inst", {30'h0, inst_aok, data_aok}, 32'h2);
    next_cyc();
    inst_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'hAAAA_0000;
    @(negedge clk);
    check_val("t1_dok1", {30'h0, inst_dok, data_dok}, 32'h1);
    check_val("t1_data_rdata", data_rdata, 32'hAAAA_0000);
    check_val("t1_inst_rdata0", inst_rdata, 32'h0);
    next_cyc();
    sram_rdata = 32'h0000_5555;
    @(negedge clk);
    check_val("t1_dok2", {30'h0, inst_dok, data_dok}, 32'h2);
    check_val("t1_inst_rdata", inst_rdata, 32'h0000_5555);
    next_cyc();
    sram_data_ok = 1'b0;
`endif

    // data held in LOCK while inst toggles
    data_req = 1'b1; data_addr = 32'h0000_1000; inst_addr = 32'h1C00_0040; sram_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inst_req = (i == 1);
      @(negedge clk);
      check_val($sformatf("t2_addr%0d", i), sram_addr, 32'h0000_1000);
      check_val($sformatf("t2_inst_aok%0d", i), {31'h0, inst_aok}, 32'h0);
      next_cyc();
    end
    sram_addr_ok = 1'b1; inst_req = 1'b1;
    @(negedge clk);
    check_val("t2_aok_data", {30'h0, inst_aok, data_aok}, 32'h1);
    next_cyc();
    data_req = 1'b0;
    @(negedge clk);
    check_val("t2_aok_inst", {30'h0, inst_aok, data_aok}, 32'h2);
    check_val("t2_addr_inst", sram_addr, 32'h1C00_0040);
    next_cyc();
    inst_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'h11;
    @(negedge clk);
    check_val("t2_dok1", {30'h0, inst_dok, data_dok}, 32'h1);
    next_cyc();
    @(negedge clk);
    check_val("t2_dok2", {30'h0, inst_dok, data_dok}, 32'h2);
    next_cyc();
    sram_data_ok = 1'b0;

    // FIFO full blocks the fifth fetch; a same-cycle pop does not unblock
    inst_req = 1'b1; inst_addr = 32'h1C00_0100; sram_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("t3_fill_aok%0d", i), {31'h0, inst_aok}, 32'h1);
      next_cyc();
    end
    @(negedge clk);
    check_val("t3_full_req", {31'h0, sram_req}, 32'h0);
    check_val("t3_full_aok", {31'h0, inst_aok}, 32'h0);
    next_cyc();
    sram_data_ok = 1'b1; sram_rdata = 32'h100;
    @(negedge clk);
    check_val("t3_pop_req", {31'h0, sram_req}, 32'h0);
    check_val("t3_pop_dok", {31'h0, inst_dok}, 32'h1);
    next_cyc();
    sram_data_ok = 1'b0;
    @(negedge clk);
    check_val("t3_resume_req", {31'h0, sram_req}, 32'h1);
    check_val("t3_resume_aok", {31'h0, inst_aok}, 32'h1);
    next_cyc();
    inst_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("t3_drain%0d", i), {30'h0, inst_dok, data_dok}, 32'h2);
      next_cyc();
    end
    sram_data_ok = 1'b0;

    // data write then inst read, responses routed in order
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_size = 2'd2;
    data_addr = 32'h0000_2000; data_wdata = 32'hDEAD_BEEF; sram_addr_ok = 1'b1;
    @(negedge clk);
    check_val("t4_wr", {31'h0, sram_wr}, 32'h1);
    check_val("t4_wstrb", {28'h0, sram_wstrb}, 32'hF);
    check_val("t4_size", {30'h0, sram_size}, 32'h2);
    check_val("t4_wdata", sram_wdata, 32'hDEAD_BEEF);
    check_val("t4_aok_data", {30'h0, inst_aok, data_aok}, 32'h1);
    next_cyc();
    data_req = 1'b0; data_wr = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0080;
    @(negedge clk);
    check_val("t4_rd_wr", {31'h0, sram_wr}, 32'h0);
    check_val("t4_aok_inst", {30'h0, inst_aok, data_aok}, 32'h2);
    next_cyc();
    inst_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'h0;
    @(negedge clk);
    check_val("t4_dok_wr", {30'h0, inst_dok, data_dok}, 32'h1);
    next_cyc();
    sram_rdata = 32'h1234_5678;
    @(negedge clk);
    check_val("t4_dok_rd", {30'h0, inst_dok, data_dok}, 32'h2);
    check_val("t4_inst_rdata", inst_rdata, 32'h1234_5678);
    check_val("t4_data_rdata", data_rdata, 32'h0);
    next_cyc();
    sram_data_ok = 1'b0;

    // reset with two outstanding discards tags
    inst_req = 1'b1; inst_addr = 32'h1C00_0200; sram_addr_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val($sformatf("t5_aok%0d", i), {31'h0, inst_aok}, 32'h1);
      next_cyc();
    end
    resetn = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'h7777;
    @(negedge clk);
    check_val("t5_rst_dok", {30'h0, inst_dok, data_dok}, 32'h0);
    check_val("t5_rst_req", {31'h0, sram_req}, 32'h0);
    next_cyc();
    resetn = 1'b1; inst_req = 1'b0; sram_addr_ok = 1'b0;
    @(negedge clk);
    check_val("t5_stray_dok", {30'h0, inst_dok, data_dok}, 32'h0);
    check_val("t5_stray_rdata", inst_rdata, 32'h0);
    next_cyc();
    sram_data_ok = 1'b0; inst_req = 1'b1; sram_addr_ok = 1'b1;
    @(negedge clk);
    check_val("t5_regrant_req", {31'h0, sram_req}, 32'h1);
    check_val("t5_regrant_aok", {31'h0, inst_aok}, 32'h1);
    next_cyc();
    inst_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'h0000_CAFE;
    @(negedge clk);
    check_val("t5_resp_dok", {30'h0, inst_dok, data_dok}, 32'h2);
    check_val("t5_resp_rdata", inst_rdata, 32'h0000_CAFE);
    next_cyc();
    sram_data_ok = 1'b0;
    next_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
